wave_capture: RTL and testbench

- Acquisition front end for the scope display path.
- Takes a stream of ADC samples, decimates it, and detects a trigger crossing.
- After a trigger, writes exactly one frame of 2^AW samples into the wave buffer through its write port (wraddr/wrdata/we).
- Holds the frame until the display side acknowledges it, then re-arms (continuous mode) or waits for a software arm (single mode).

---
 rtl/wave_capture_if.sv | 34 +++
 rtl/wave_capture.sv | 143 ++++++++++++++
 tb/tb_wave_capture.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wave_capture_if.sv
// wave_capture_if: sample/control inputs and buffer write port of the
// acquisition front end. The master drives samples and controls; the slave
// (wave_capture) drives the buffer write port and status.
interface wave_capture_if #(
  parameter int AW = 10,
  parameter int DW = 9
);
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic [7:0]    decim;
  logic [DW-1:0] trig_level;
  logic          trig_slope;
  logic          continuous;
  logic          arm;
  logic          frame_ack;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic          we;
  logic          busy;
  logic          done;
  logic          auto_trig;

  modport master (
    output sample_in, sample_valid, decim, trig_level, trig_slope,
           continuous, arm, frame_ack,
    input  wraddr, wrdata, we, busy, done, auto_trig
  );

  modport slave (
    input  sample_in, sample_valid, decim, trig_level, trig_slope,
           continuous, arm, frame_ack,
    output wraddr, wrdata, we, busy, done, auto_trig
  );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: decimates an ADC sample stream, waits for a trigger crossing
// and writes exactly one frame of 2^AW samples into the wave buffer, then
// holds the frame until the display acknowledges it.
// Optional feature: define SCOPE_AUTO_TRIG_EN to force a trigger after
// AUTO_TIMEOUT accepted samples in ARMED without a crossing.
module wave_capture #(
  parameter int AW           = 10,
  parameter int DW           = 9,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  wave_capture_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  if (AUTO_TIMEOUT < 1 || AUTO_TIMEOUT > 65535) begin : g_bad_timeout
    $error("wave_capture: AUTO_TIMEOUT must be in 1..65535");
  end

  state_t        r_state, w_next;
  logic [7:0]    r_dcnt;
  logic [DW-1:0] r_prev;
  logic          r_prev_valid;
  logic [AW-1:0] r_wraddr;
  logic [DW-1:0] r_wrdata;
  logic          r_we;

  logic w_accept, w_rise, w_fall, w_cross, w_timeout;
  logic w_trigger, w_cap_write, w_enter_armed;

  assign w_accept = bus.sample_valid && (r_dcnt == bus.decim);

  // Crossing needs a previous accepted sample from this arming, so a level
  // already past the threshold at arm time cannot fire on its own.
  assign w_rise  = r_prev_valid && (r_prev < bus.trig_level) && (bus.sample_in >= bus.trig_level);
  assign w_fall  = r_prev_valid && (r_prev > bus.trig_level) && (bus.sample_in <= bus.trig_level);
  assign w_cross = bus.trig_slope ? w_fall : w_rise;

  assign w_enter_armed = (w_next == S_ARMED) && (r_state != S_ARMED);

`ifdef SCOPE_AUTO_TRIG_EN
  localparam logic [15:0] TIMEOUT_M1 = 16'(AUTO_TIMEOUT - 1);

  logic [15:0] r_acnt;
  logic        r_auto_trig;

  assign w_timeout = w_accept && (r_acnt == TIMEOUT_M1);

  // Accepted-sample counter for the forced trigger, restarted on each arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_acnt <= '0;
    else if (w_enter_armed)                     r_acnt <= '0;
    else if (r_state == S_ARMED && w_accept)    r_acnt <= r_acnt + 16'd1;
  end

  // A real crossing wins over a coincident timeout, so auto_trig stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_auto_trig <= 1'b0;
    else if (w_trigger) r_auto_trig <= !w_cross;
  end

  assign bus.auto_trig = r_auto_trig;
`else
  assign w_timeout     = 1'b0;
  assign bus.auto_trig = 1'b0;
`endif

  assign w_trigger   = (r_state == S_ARMED) && w_accept && (w_cross || w_timeout);
  // Once the write to LAST_ADDR is out, further samples are dropped.
  assign w_cap_write = (r_state == S_CAPTURE) && w_accept && (r_wraddr != LAST_ADDR);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses <= so every flop sees pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; arm in ARMED/CAPTURE and frame_ack outside DONE ignored.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.arm) w_next = S_ARMED;
      S_ARMED:   if (w_trigger) w_next = S_CAPTURE;
      S_CAPTURE: if (r_wraddr == LAST_ADDR) w_next = S_DONE;
      S_DONE: begin
        if (bus.arm)            w_next = S_ARMED;
        else if (bus.frame_ack) w_next = bus.continuous ? S_ARMED : S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Decimation counter: advances on valid samples, restarts on arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_dcnt <= '0;
    else if (w_enter_armed)    r_dcnt <= '0;
    else if (bus.sample_valid) r_dcnt <= (r_dcnt == bus.decim) ? 8'd0 : r_dcnt + 8'd1;
  end

  // Previous accepted sample for crossing detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else if (w_enter_armed) begin
      r_prev_valid <= 1'b0;
    end else if (w_accept) begin
      r_prev       <= bus.sample_in;
      r_prev_valid <= 1'b1;
    end
  end

  // Registered buffer write port: one we pulse per trigger/captured sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_wraddr <= '0;
      r_wrdata <= '0;
    end else begin
      r_we <= w_trigger || w_cap_write;
      if (w_trigger) begin
        r_wraddr <= '0;
        r_wrdata <= bus.sample_in;
      end else if (w_cap_write) begin
        r_wraddr <= r_wraddr + 1'b1;
        r_wrdata <= bus.sample_in;
      end
    end
  end

  assign bus.wraddr = r_wraddr;
  assign bus.wrdata = r_wrdata;
  assign bus.we     = r_we;
  assign bus.busy   = (r_state == S_ARMED) || (r_state == S_CAPTURE);
  assign bus.done   = (r_state == S_DONE);

endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: directed bench for wave_capture (AW=10, DW=9,
// AUTO_TIMEOUT=16). Expected frames are derived from the stimulus formulas.
module tb_wave_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wave_capture_if #(.AW(10), .DW(9)) bus ();

  wave_capture #(.AW(10), .DW(9), .AUTO_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus generator and frame expectation
  int         mode;        // 0 ramp up, 1 ramp down, 2 constant
  logic [8:0] const_val;
  int         exp_start, exp_step, exp_gap;
  logic [8:0] exp_d;

  // Results of the last run/feed
  int         wr_cnt, wr_bad, gap_bad, first_idx, last_idx, nw;
  logic [8:0] first_data;
  logic       timed_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] sample_at(input int i);
    case (mode)
      0:       return 9'(i);
      1:       return 9'(511 - i);
      default: return const_val;
    endcase
  endfunction

  // Feeds one valid sample per cycle; records and checks every write
  // against exp_start + k*exp_step (mod 512) at address k.
  task automatic run(input int budget, input int stop_addr, input int arm_at);
    wr_cnt = 0; wr_bad = 0; gap_bad = 0; first_idx = -1; last_idx = 0;
    first_data = '0; timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      bus.sample_in    = sample_at(i);
      bus.sample_valid = 1'b1;
      bus.arm          = (i == arm_at);
      tick();
      bus.arm = 1'b0;
      if (bus.we === 1'b1) begin
        if (wr_cnt == 0) begin
          first_idx  = i;
          first_data = bus.wrdata;
        end else if (exp_gap > 0 && (i - last_idx) != exp_gap) begin
          gap_bad++;
        end
        exp_d = 9'(exp_start + wr_cnt * exp_step);
        if (bus.wraddr !== 10'(wr_cnt) || bus.wrdata !== exp_d) wr_bad++;
        last_idx = i;
        wr_cnt++;
        if (wr_cnt - 1 == stop_addr) begin
          timed_out = 1'b0;
          break;
        end
      end
      if (bus.done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [8:0] v);
    nw = 0;
    for (int i = 0; i < n; i++) begin
      bus.sample_in    = v;
      bus.sample_valid = 1'b1;
      tick();
      if (bus.we === 1'b1) nw++;
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse(input logic a, input logic ack);
    bus.arm       = a;
    bus.frame_ack = ack;
    tick();
    bus.arm       = 1'b0;
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.decim = 8'd0;
    bus.trig_level = 9'd256; bus.trig_slope = 1'b0; bus.continuous = 1'b0;
    bus.arm = 1'b0; bus.frame_ack = 1'b0;
    mode = 0; const_val = '0; exp_start = 0; exp_step = 1; exp_gap = 0;

    // Reset state
    #1;
    check("rst_wraddr", 32'(bus.wraddr), 0);
    check("rst_wrdata", 32'(bus.wrdata), 0);
    check("rst_we", 32'(bus.we), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_auto", 32'(bus.auto_trig), 0);
    tick(); tick();
    #2 rst = 1'b0;
    tick();

    // Rising trigger, decim=0, ramp mod 512
    pulse(1'b1, 1'b0);
    check("t1_busy_after_arm", 32'(bus.busy), 1);
    mode = 0; exp_start = 256; exp_step = 1; exp_gap = 0;
    run(3000, -1, -1);
    check("t1_timeout", 32'(timed_out), 0);
    check("t1_first_idx", 32'(first_idx), 256);
    check("t1_first_data", 32'(first_data), 256);
    check("t1_writes", 32'(wr_cnt), 1024);
    check("t1_bad_writes", 32'(wr_bad), 0);
    check("t1_done", 32'(bus.done), 1);
    check("t1_busy", 32'(bus.busy), 0);
    check("t1_we_low", 32'(bus.we), 0);

    // Frame held until ack; continuous=0 ack returns to IDLE
    feed(20, 9'd7);
    check("t2_hold_writes", 32'(nw), 0);
    check("t2_hold_done", 32'(bus.done), 1);
    pulse(1'b0, 1'b1);
    check("t2_idle_done", 32'(bus.done), 0);
    check("t2_idle_busy", 32'(bus.busy), 0);
    feed(50, 9'd300);
    check("t2_idle_writes", 32'(nw), 0);

    // First-sample guard: constant above level must not trigger
    pulse(1'b1, 1'b0);
    feed(20, 9'd300);
    check("t3_const_writes", 32'(nw), 0);
    check("t3_const_busy", 32'(bus.busy), 1);
    pulse(1'b0, 1'b1);
    check("t3_ack_ignored", 32'(bus.busy), 1);
    feed(1, 9'd200);
    check("t3_below_writes", 32'(nw), 0);
    mode = 2; const_val = 9'd300; exp_start = 300; exp_step = 0; exp_gap = 0;
    run(600, 500, -1);
    check("t3_timeout", 32'(timed_out), 0);
    check("t3_first_idx", 32'(first_idx), 0);
    check("t3_first_data", 32'(first_data), 300);
    check("t3_writes", 32'(wr_cnt), 501);
    check("t3_bad_writes", 32'(wr_bad), 0);
    check("t3_at_500", 32'(bus.wraddr), 500);

    // Async reset mid-capture, between clock edges
    #2 rst = 1'b1;
    #1;
    check("t3_rst_wraddr", 32'(bus.wraddr), 0);
    check("t3_rst_wrdata", 32'(bus.wrdata), 0);
    check("t3_rst_we", 32'(bus.we), 0);
    check("t3_rst_busy", 32'(bus.busy), 0);
    #3 rst = 1'b0;
    feed(50, 9'd300);
    check("t3_post_rst_writes", 32'(nw), 0);
    check("t3_post_rst_busy", 32'(bus.busy), 0);

    // Falling trigger with decim=3, continuous mode
    bus.decim = 8'd3; bus.trig_slope = 1'b1; bus.trig_level = 9'd100;
    bus.continuous = 1'b1;
    pulse(1'b1, 1'b0);
    mode = 1; exp_start = 100; exp_step = -4; exp_gap = 4;
    run(5000, -1, -1);
    check("t4_timeout", 32'(timed_out), 0);
    check("t4_first_idx", 32'(first_idx), 411);
    check("t4_first_data", 32'(first_data), 100);
    check("t4_writes", 32'(wr_cnt), 1024);
    check("t4_bad_writes", 32'(wr_bad), 0);
    check("t4_gap", 32'(gap_bad), 0);
    check("t4_done", 32'(bus.done), 1);
    pulse(1'b0, 1'b1);
    check("t4_rearm_busy", 32'(bus.busy), 1);
    check("t4_rearm_done", 32'(bus.done), 0);

    // Second frame after auto re-arm; arm during capture is ignored
    bus.decim = 8'd0; bus.trig_slope = 1'b0; bus.trig_level = 9'd256;
    mode = 0; exp_start = 256; exp_step = 1; exp_gap = 0;
    run(3000, -1, 600);
    check("t5_timeout", 32'(timed_out), 0);
    check("t5_first_idx", 32'(first_idx), 256);
    check("t5_writes", 32'(wr_cnt), 1024);
    check("t5_bad_writes", 32'(wr_bad), 0);
    check("t5_done", 32'(bus.done), 1);
    bus.continuous = 1'b0;
    pulse(1'b1, 1'b1);
    check("t5_arm_ack_busy", 32'(bus.busy), 1);
    check("t5_arm_ack_done", 32'(bus.done), 0);

    // Constant input below level: forced trigger or indefinite wait
`ifdef SCOPE_AUTO_TRIG_EN
    mode = 2; const_val = 9'd50; exp_start = 50; exp_step = 0; exp_gap = 0;
    run(2000, -1, -1);
    check("t6_timeout", 32'(timed_out), 0);
    check("t6_first_idx", 32'(first_idx), 15);
    check("t6_writes", 32'(wr_cnt), 1024);
    check("t6_bad_writes", 32'(wr_bad), 0);
    check("t6_auto_set", 32'(bus.auto_trig), 1);
    bus.continuous = 1'b1;
    pulse(1'b0, 1'b1);
    feed(1, 9'd200);
    check("t6_auto_held", 32'(bus.auto_trig), 1);
    feed(1, 9'd300);
    check("t6_real_write", 32'(nw), 1);
    check("t6_auto_clear", 32'(bus.auto_trig), 0);
`else
    feed(100, 9'd50);
    check("t6_no_writes", 32'(nw), 0);
    check("t6_still_armed", 32'(bus.busy), 1);
    check("t6_auto_low", 32'(bus.auto_trig), 0);
`endif

    #2 rst = 1'b1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
